// File: rtl/rpn_expr_arbiter.sv
// Shares one RPN calculator between two token requesters, one whole expression per grant, round-robin.
// Latency: grant 1 cycle after request in IDLE; a token reaches c_* 1 cycle after its rN_ack; result held on oN_* until acked.
// Backpressure: rN_ack follows the one-entry skid (empty or draining via c_ack); the non-owner is never acked and its token stays pending.
module rpn_expr_arbiter #(
  parameter int DATA_W     = 32,
  parameter int MAX_TOKENS = 64,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_stb,
  input  logic [DATA_W-1:0] r0_dat,
  input  logic              r0_op,
  output logic              r0_ack,
  input  logic              r1_stb,
  input  logic [DATA_W-1:0] r1_dat,
  input  logic              r1_op,
  output logic              r1_ack,
  output logic              c_stb,
  output logic [DATA_W-1:0] c_dat,
  output logic              c_op,
  input  logic              c_ack,
  input  logic              c_res_stb,
  input  logic [DATA_W-1:0] c_res_dat,
  output logic              c_res_ack,
  output logic              o0_stb,
  output logic [DATA_W-1:0] o0_dat,
  output logic              o0_err,
  input  logic              o0_ack,
  output logic              o1_stb,
  output logic [DATA_W-1:0] o1_dat,
  output logic              o1_err,
  input  logic              o1_ack,
  output logic              busy,
  output logic              owner
);

  localparam int CW = $clog2(MAX_TOKENS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] OP_EQ = DATA_W'(4);

  typedef enum logic [2:0] {IDLE, FWD, DRAIN, WAIT_RES, RET} state_t;

  state_t            state_q;
  logic              owner_q;
  logic              last_q;      // requester served last; loses the next tie
  logic [CW-1:0]     cnt_q;
  logic [TW-1:0]     timer_q;
  logic              skid_vld_q;
  logic [DATA_W-1:0] skid_dat_q;
  logic              skid_op_q;
  logic              err_q;
  logic [DATA_W-1:0] res_q;

  logic              own_stb;
  logic [DATA_W-1:0] own_dat;
  logic              own_op;
  logic              own_res_ack;
  logic              fwd_rdy;
  logic              take;
  logic              bad_op;
  logic              is_eq;
  logic              grant;
  logic [CW-1:0]     cnt_d;

  // Select the owning requester's token and result handshake.
  always_comb begin
    own_stb     = owner_q ? r1_stb : r0_stb;
    own_dat     = owner_q ? r1_dat : r0_dat;
    own_op      = owner_q ? r1_op  : r0_op;
    own_res_ack = owner_q ? o1_ack : o0_ack;
  end

  // Token acceptance and classification while forwarding.
  always_comb begin
    fwd_rdy = (state_q == FWD) && (!skid_vld_q || c_ack);
    take    = fwd_rdy && own_stb;
    bad_op  = own_op && ((own_dat == '0) || (own_dat > OP_EQ));
    is_eq   = own_op && (own_dat == OP_EQ);
    cnt_d   = cnt_q + CW'(1);
  end

  // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    if (r0_stb && !r1_stb) begin
      grant = 1'b0;
    end else if (!r0_stb && r1_stb) begin
      grant = 1'b1;
    end else begin
      grant = ~last_q;
    end
  end

  assign r0_ack    = fwd_rdy && !owner_q;
  assign r1_ack    = fwd_rdy && owner_q;
  assign c_stb     = skid_vld_q;
  assign c_dat     = skid_dat_q;
  assign c_op      = skid_op_q;
  assign c_res_ack = (state_q == WAIT_RES);
  assign o0_stb    = (state_q == RET) && !owner_q;
  assign o1_stb    = (state_q == RET) && owner_q;
  assign o0_dat    = res_q;
  assign o1_dat    = res_q;
  assign o0_err    = o0_stb && err_q;
  assign o1_err    = o1_stb && err_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

  // Expression FSM: grant, forward through the skid, drain, await result, return it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      timer_q    <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      skid_op_q  <= 1'b0;
      err_q      <= 1'b0;
      res_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (r0_stb || r1_stb) begin
            owner_q <= grant;
            state_q <= FWD;
          end
        end
        FWD: begin
          if (c_ack) skid_vld_q <= 1'b0;
          if (take) begin
            skid_vld_q <= 1'b1;
            cnt_q      <= cnt_d;
            if (bad_op || ((cnt_d == CW'(MAX_TOKENS)) && !is_eq)) begin
              // Close the expression early so the calculator still sees a terminator.
              skid_dat_q <= OP_EQ;
              skid_op_q  <= 1'b1;
              err_q      <= 1'b1;
              state_q    <= DRAIN;
            end else begin
              skid_dat_q <= own_dat;
              skid_op_q  <= own_op;
              if (is_eq) state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!skid_vld_q || c_ack) begin
            skid_vld_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (c_res_stb) begin
            res_q   <= c_res_dat;
            state_q <= RET;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            state_q <= RET;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RET: begin
          if (own_res_ack) begin
            last_q  <= owner_q;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_expr_arbiter.sv
// Bench for rpn_expr_arbiter: directed steps plus randomized expressions against a list-level reference.
// Latency: drives on posedge+1, samples on negedge.
// Backpressure: calculator model stalls c_ack randomly, delays results, or stays mute for the timeout case.
module tb_rpn_expr_arbiter;

  localparam int DW   = 32;
  localparam int MAXT = 8;
  localparam int TMO  = 20;

  typedef struct packed {
    logic          op;
    logic [DW-1:0] dat;
  } tok_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_stb = 1'b0, r0_op = 1'b0, r1_stb = 1'b0, r1_op = 1'b0;
  logic [DW-1:0] r0_dat = '0, r1_dat = '0;
  logic          r0_ack, r1_ack;
  logic          c_stb, c_op, c_res_ack;
  logic [DW-1:0] c_dat;
  logic          c_ack, c_res_stb;
  logic [DW-1:0] c_res_dat;
  logic          o0_stb, o0_err, o1_stb, o1_err;
  logic [DW-1:0] o0_dat, o1_dat;
  logic          o0_ack = 1'b0, o1_ack = 1'b0;
  logic          busy, owner;

  int checks = 0;
  int failures = 0;

  // written by the calculator/monitor process only
  tok_t          fwd_log[$];
  tok_t          calc_q[$];
  int            acc0 = 0, acc1 = 0, o1_cnt = 0, wait_cyc = 0, res_delay = 0;
  bit            res_pending = 0, res_taken = 0;
  logic [DW-1:0] calc_res = '0;
  // written by the main process only
  bit            calc_mute = 0, calc_stall = 0, calc_hold = 0, tb_last = 1;

  rpn_expr_arbiter #(.DATA_W(DW), .MAX_TOKENS(MAXT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .r0_stb(r0_stb), .r0_dat(r0_dat), .r0_op(r0_op), .r0_ack(r0_ack),
    .r1_stb(r1_stb), .r1_dat(r1_dat), .r1_op(r1_op), .r1_ack(r1_ack),
    .c_stb(c_stb), .c_dat(c_dat), .c_op(c_op), .c_ack(c_ack),
    .c_res_stb(c_res_stb), .c_res_dat(c_res_dat), .c_res_ack(c_res_ack),
    .o0_stb(o0_stb), .o0_dat(o0_dat), .o0_err(o0_err), .o0_ack(o0_ack),
    .o1_stb(o1_stb), .o1_dat(o1_dat), .o1_err(o1_err), .o1_ack(o1_ack),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic tok_t mk(input logic op, input logic [DW-1:0] dat);
    tok_t t;
    t.op  = op;
    t.dat = dat;
    return t;
  endfunction

  // Plain RPN evaluation, stops at '='; empty stack reads as 0.
  function automatic logic [DW-1:0] rpn_eval(input tok_t q[$]);
    logic [DW-1:0] st[$];
    logic [DW-1:0] a, b;
    for (int i = 0; i < q.size(); i++) begin
      if (!q[i].op) begin
        st.push_back(q[i].dat);
      end else if (q[i].dat == 4) begin
        break;
      end else begin
        b = '0; a = '0;
        if (st.size() > 0) b = st.pop_back();
        if (st.size() > 0) a = st.pop_back();
        case (q[i].dat)
          1:       st.push_back(a * b);
          2:       st.push_back(a + b);
          default: st.push_back(a - b);
        endcase
      end
    end
    if (st.size() > 0) return st[st.size()-1];
    return '0;
  endfunction

  // Reference: which tokens the calculator must receive, the value and the error flag.
  task automatic ref_model(input tok_t e[$], output tok_t fw[$], output logic [DW-1:0] val, output bit err);
    tok_t t;
    fw = {};
    err = 0;
    for (int i = 0; i < e.size(); i++) begin
      t = e[i];
      if (t.op && (t.dat < 1 || t.dat > 4)) begin
        fw.push_back(mk(1'b1, 4)); err = 1; break;
      end
      if (i + 1 == MAXT && !(t.op && t.dat == 4)) begin
        fw.push_back(mk(1'b1, 4)); err = 1; break;
      end
      fw.push_back(t);
      if (t.op && t.dat == 4) break;
    end
    val = rpn_eval(e);
  endtask

  task automatic gen_expr(input int k, output tok_t e[$]);
    e = {};
    e.push_back(mk(1'b0, $urandom_range(0, 50)));
    for (int j = 1; j < k; j++) begin
      e.push_back(mk(1'b0, $urandom_range(0, 50)));
      e.push_back(mk(1'b1, $urandom_range(1, 3)));
    end
    e.push_back(mk(1'b1, 4));
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int n, input logic v, input tok_t t);
    if (n == 0) begin r0_stb = v; r0_dat = t.dat; r0_op = t.op; end
    else begin r1_stb = v; r1_dat = t.dat; r1_op = t.op; end
  endtask

  // Present tokens one by one; stop once all are taken or the result shows up.
  task automatic send(input int n, input tok_t e[$]);
    int i = 0;
    int guard = 0;
    while (i < e.size()) begin
      drive_req(n, 1'b1, e[i]);
      @(negedge clk);
      if ((n == 0) ? o0_stb : o1_stb) break;
      if ((n == 0) ? r0_ack : r1_ack) i++;
      guard++;
      if (guard > 400) begin chk("send_budget", 0, 1); break; end
      @(posedge clk); #1;
    end
    drive_req(n, 1'b0, mk(1'b0, 0));
  endtask

  // Wait for the result, take it after a random delay; report cycle and the other side's accept count.
  task automatic collect(input int n, output logic [DW-1:0] d, output logic er, output int t, output int oth);
    int g = 0;
    d = '0; er = 1'b0; t = 0; oth = 0;
    while (!((n == 0) ? o0_stb : o1_stb)) begin
      @(negedge clk);
      g++;
      if (g > 3000) begin chk("res_wait", 0, 1); return; end
    end
    d  = (n == 0) ? o0_dat : o1_dat;
    er = (n == 0) ? o0_err : o1_err;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(posedge clk); #1;
    if (n == 0) o0_ack = 1'b1; else o1_ack = 1'b1;
    @(negedge clk);
    oth = (n == 0) ? acc1 : acc0;
    t   = $time;
    @(posedge clk); #1;
    o0_ack = 1'b0; o1_ack = 1'b0;
  endtask

  task automatic cmp_stream(input int base, input tok_t fw[$]);
    chk("fwd_len", fwd_log.size() - base, fw.size());
    for (int j = 0; j < fw.size(); j++)
      if (base + j < fwd_log.size()) chk("fwd_tok", fwd_log[base+j], fw[j]);
  endtask

  task automatic run_single(input int n, input tok_t e[$]);
    tok_t fw[$];
    logic [DW-1:0] val, d;
    bit err;
    logic er;
    int t, oth, fbase, abase;
    ref_model(e, fw, val, err);
    fbase = fwd_log.size();
    abase = (n == 0) ? acc0 : acc1;
    send(n, e);
    collect(n, d, er, t, oth);
    chk("err", er, err);
    if (!err) chk("dat", d, val);
    chk("accepted", ((n == 0) ? acc0 : acc1) - abase, fw.size());
    cmp_stream(fbase, fw);
    tb_last = (n != 0);
  endtask

  task automatic run_pair(input tok_t e0[$], input tok_t e1[$]);
    tok_t fw0[$], fw1[$], cat[$];
    logic [DW-1:0] v0, v1, d0, d1;
    bit err0, err1;
    logic er0, er1;
    int t0, t1, oth0, oth1, fbase, a0, a1, first;
    first = tb_last ? 0 : 1;
    ref_model(e0, fw0, v0, err0);
    ref_model(e1, fw1, v1, err1);
    fbase = fwd_log.size();
    a0 = acc0; a1 = acc1;
    fork
      begin send(0, e0); collect(0, d0, er0, t0, oth0); end
      begin send(1, e1); collect(1, d1, er1, t1, oth1); end
    join
    chk("order_r0_first", t0 < t1, first == 0);
    chk("other_held", (first == 0) ? (oth0 - a1) : (oth1 - a0), 0);
    chk("pair_dat0", d0, v0);
    chk("pair_dat1", d1, v1);
    chk("pair_err0", er0, err0);
    chk("pair_err1", er1, err1);
    chk("pair_acc0", acc0 - a0, fw0.size());
    chk("pair_acc1", acc1 - a1, fw1.size());
    cat = {};
    if (first == 0) begin
      foreach (fw0[j]) cat.push_back(fw0[j]);
      foreach (fw1[j]) cat.push_back(fw1[j]);
    end else begin
      foreach (fw1[j]) cat.push_back(fw1[j]);
      foreach (fw0[j]) cat.push_back(fw0[j]);
    end
    cmp_stream(fbase, cat);
    tb_last = (first == 0);
  endtask

  // Calculator model and monitor: observe on negedge, drive on posedge+1.
  initial begin
    c_ack = 1'b0; c_res_stb = 1'b0; c_res_dat = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        calc_q.delete(); res_pending = 0; res_taken = 0;
      end else begin
        if (c_stb && c_ack) begin
          fwd_log.push_back(mk(c_op, c_dat));
          calc_q.push_back(mk(c_op, c_dat));
          if (c_op && c_dat == 4) begin
            calc_res = rpn_eval(calc_q);
            calc_q.delete();
            if (!calc_mute) begin res_pending = 1; res_delay = $urandom_range(0, 3); end
          end
        end
        if (c_res_stb && c_res_ack) res_taken = 1;
        if (r0_stb && r0_ack) acc0++;
        if (r1_stb && r1_ack) acc1++;
        if (o1_stb) o1_cnt++;
        if (c_res_ack) wait_cyc++;
      end
      @(posedge clk); #1;
      if (!rst) begin
        c_res_stb = 1'b0;
      end else begin
        if (res_taken) begin c_res_stb = 1'b0; res_taken = 0; end
        if (res_pending && !c_res_stb) begin
          if (res_delay == 0) begin c_res_stb = 1'b1; c_res_dat = calc_res; res_pending = 0; end
          else res_delay--;
        end
      end
      c_ack = calc_hold ? 1'b0 : (calc_stall ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  initial begin
    tok_t e0[$], e1[$], ed[$];
    logic [DW-1:0] d;
    logic er;
    int t, oth, g, o1b, wb, fbase;

    // reset state
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_c_stb", c_stb, 0);
    chk("rst_acks", {r0_ack, r1_ack, c_res_ack}, 0);
    chk("rst_ostb", {o0_stb, o1_stb, o0_err, o1_err}, 0);
    @(posedge clk); #1 rst = 1'b1;
    tb_last = 1;
    repeat (2) @(posedge clk); #1;

    // first tie after reset goes to r0; r1 then gets 10-2=8
    e0 = {mk(0, 3), mk(0, 4), mk(1, 2), mk(1, 4)};
    e1 = {mk(0, 10), mk(0, 2), mk(1, 3), mk(1, 4)};
    run_pair(e0, e1);

    // r1 served last, both request again: r0 wins, r1 held off meanwhile
    calc_stall = 1;
    gen_expr(2, e0); gen_expr(3, e1);
    run_pair(e0, e1);

    // r0 alone, no stalls: each token shows on c_* one cycle after its ack
    calc_stall = 0;
    ed = {mk(0, 3), mk(0, 4), mk(1, 2), mk(1, 4)};
    o1b = o1_cnt; fbase = fwd_log.size();
    drive_req(0, 1'b1, ed[0]);
    @(negedge clk);
    chk("idle_no_ack", r0_ack, 0);
    @(posedge clk); #1;
    for (int i = 0; i < ed.size(); i++) begin
      drive_req(0, 1'b1, ed[i]);
      g = 0;
      @(negedge clk);
      while (!r0_ack && g < 50) begin g++; @(negedge clk); end
      chk("fwd_ack", r0_ack, 1);
      @(posedge clk); #1;
      drive_req(0, 1'b0, mk(0, 0));
      @(negedge clk);
      chk("c_next_cycle", {c_stb, c_op, c_dat}, {1'b1, ed[i]});
      @(posedge clk); #1;
    end
    collect(0, d, er, t, oth);
    chk("solo_dat", d, 7);
    chk("solo_err", er, 0);
    chk("o1_silent", o1_cnt - o1b, 0);
    cmp_stream(fbase, ed);
    tb_last = 0;

    // randomized traffic with calculator stalls
    calc_stall = 1;
    for (int it = 0; it < 10; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      gen_expr($urandom_range(1, 3), e0);
      gen_expr($urandom_range(1, 3), e1);
      if (mode == 0) run_single(0, e0);
      else if (mode == 1) run_single(1, e1);
      else run_pair(e0, e1);
    end

    // illegal operator code 7 is forwarded as '=' with error
    e0 = {mk(0, 5), mk(1, 7)};
    run_single(0, e0);

    // MAX_TOKENS boundary: exactly MAXT tokens ending in '=' is legal
    gen_expr(4, e0);
    run_single(0, e0);
    // one operand too many: token MAXT replaced by '='
    gen_expr(5, e1);
    run_single(1, e1);

    // mute calculator: timeout after exactly TMO cycles in WAIT_RES
    calc_mute = 1;
    gen_expr(2, e0);
    wb = wait_cyc;
    send(0, e0);
    collect(0, d, er, t, oth);
    chk("tmo_cycles", wait_cyc - wb, TMO);
    chk("tmo_dat", d, 0);
    chk("tmo_err", er, 1);
    calc_mute = 0;
    tb_last = 0;

    // async reset while r1 owns with a full skid
    calc_hold = 1;
    @(posedge clk); #1;
    drive_req(1, 1'b1, mk(0, 9));
    repeat (3) @(negedge clk);
    chk("pre_rst_c_stb", c_stb, 1);
    chk("pre_rst_owner", owner, 1);
    chk("pre_rst_r1_ack", r1_ack, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_c_stb", c_stb, 0);
    chk("arst_busy", busy, 0);
    chk("arst_owner", owner, 0);
    chk("arst_outs", {r1_ack, o1_stb, o0_stb, c_res_ack}, 0);
    drive_req(1, 1'b0, mk(0, 0));
    @(posedge clk); #1;
    rst = 1'b1;
    calc_hold = 0;
    tb_last = 1;
    repeat (2) @(posedge clk); #1;
    gen_expr(2, e0); gen_expr(2, e1);
    run_pair(e0, e1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpn_expr_arbiter.md
Name: rpn_expr_arbiter

Overview:
Shares one rpncalc instance between two token-stream requesters, each a state_machine-style converter output.
- Grants the calculator to one requester for a whole RPN expression, from first operand to '=' token.
- Forwards that requester's tokens, then returns the calculator result to the owning requester only.
- Arbitration is round-robin per expression.

Parameters:
DATA_W, 32, token/result data width
MAX_TOKENS, 64, max tokens per expression including '='; the overflow token is replaced by '='
TIMEOUT, 1023, max cycles waiting for the calculator result after '=' is forwarded

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
r0_stb  in  1  requester 0 token valid
r0_dat  in  DATA_W  requester 0 token: operand, or operator code (1 '*', 2 '+', 3 '-', 4 '=')
r0_op  in  1  requester 0 token is operator
r0_ack  out  1  requester 0 token accepted
r1_stb, r1_dat, r1_op, r1_ack  same as r0_*, requester 1
c_stb  out  1  token valid to calculator
c_dat  out  DATA_W  token to calculator
c_op  out  1  operator flag to calculator
c_ack  in  1  calculator accepted token
c_res_stb  in  1  calculator result valid
c_res_dat  in  DATA_W  calculator result (signed)
c_res_ack  out  1  result accepted
o0_stb  out  1  result valid to requester 0
o0_dat  out  DATA_W  result
o0_err  out  1  result invalid: illegal operator, overflow or timeout
o0_ack  in  1  requester 0 took result
o1_stb, o1_dat, o1_err, o1_ack  same as o0_*, requester 1
busy  out  1  state != IDLE
owner  out  1  current or last grant index

Behaviour:
- Transfer on any stb/ack pair occurs in a cycle where both are high. A source holds stb and dat stable until the transfer.
- Reset (rst=0, async):
  - state IDLE; all *_stb, *_ack, *_err, busy, owner, token count, timer and skid register cleared to 0.
  - Round-robin pointer set so r0 wins the first tie.
- States: IDLE, FWD, DRAIN, WAIT_RES, RET.
- IDLE:
  - Consumes no tokens.
  - If exactly one rN_stb is high, grant it. If both are high, grant the requester not served last.
  - owner updated and state moves to FWD on the next edge.
- FWD:
  - One-entry skid register drives c_stb/c_dat/c_op.
  - rOwner_ack = (state==FWD) && (!skid_valid || c_ack), combinational. The non-owner ack stays 0.
  - An accepted token loads the skid register; the token appears on c_* the next cycle. Sustained rate is 1 token/cycle.
  - Token count increments per accepted token.
  - Operator with dat outside 1..4: forwarded as code 4, sticky err set, state moves to DRAIN.
  - Accepted token numbered MAX_TOKENS that is not '=': forwarded as code 4, err set, state moves to DRAIN.
  - Legal '=': state moves to DRAIN.
- DRAIN: no acks to requesters. When the skid register empties via c_ack, state moves to WAIT_RES and the timer is cleared.
- WAIT_RES:
  - c_res_ack=1 combinational; it is 0 in every other state.
  - On c_res_stb, latch c_res_dat and move to RET.
  - Timer reaching TIMEOUT: result 0, err=1, move to RET.
  - c_res_stb and timeout in the same cycle: the result wins, and err keeps its sticky value.
- RET:
  - oOwner_stb=1 with the latched dat/err, held until oOwner_ack. The other o*_stb stays 0.
  - On ack, move to IDLE, record owner as last served, clear err and token count.
  - The next grant decision is made in IDLE one cycle later.
- Requester stb in a non-granted or non-FWD state is ignored and never lost; it remains pending at the source.
- Reset mid-expression aborts at once: no result is returned and the calculator is reset by the same rst.

Test Plan:
- r0 sends 3,4,'+','=' alone; calc returns 7 -> o0_stb with o0_dat=7, o0_err=0. o1_stb never asserted. Tokens reach c_* one cycle after r0_ack.
- r0 and r1 both raise stb in IDLE after reset -> r0 granted first. After o0_ack, r1's expression (10,2,'-','=') forwarded, giving o1_dat=8.
- r1 served last, then both request simultaneously -> r0 granted. No r1 token is accepted until RET for r0 completes.
- r0 sends 5 then operator code 7 -> c_dat=4, c_op=1 forwarded. Result delivered with o0_err=1.
- Calculator never raises c_res_stb -> exactly TIMEOUT cycles after WAIT_RES entry, o0_stb=1, o0_dat=0, o0_err=1.
- rst=0 asserted in FWD with skid full -> all outputs 0 immediately (asynchronous). After release, state IDLE and r0 wins the next tie.
